dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the byte-addressed data RAM (`ram2port` write/read address, write data, write enable and read data interface).
- Shares the single RAM between port A (load/store unit) and port B (debug/DMA loader).
- Round-robin arbitration; one access outstanding at a time.
- Sub-word stores are handled as a read-modify-write, because the RAM always writes 4 bytes at `w_addr..w_addr+3`.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer sharing one byte-addressed data RAM between two requesters.
// Optional misaligned-access error responses are enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter bit RESET_PRIO_B = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  a_we,
  input  logic [1:0]            a_size,
  output logic                  a_resp_valid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_err,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [DATA_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic                  b_we,
  input  logic [1:0]            b_size,
  output logic                  b_resp_valid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_err,
  output logic [DATA_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd,
  output logic [DATA_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_wd,
  output logic                  ram_we,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RMW_WR, RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_prio_b, r_sel_b, r_err, r_half;
  logic [DATA_WIDTH-1:0] r_rdata, r_addr;
  logic [15:0]           r_wdata;

  logic                  w_grant_a, w_grant_b, w_accept;
  logic [DATA_WIDTH-1:0] w_addr, w_wdata;
  logic                  w_we, w_word, w_misalign, w_rmw, w_resp;
  logic [1:0]            w_size;

  assign w_grant_b = (r_state == IDLE) && !rst && b_valid && (!a_valid || r_prio_b);
  assign w_grant_a = (r_state == IDLE) && !rst && a_valid && !w_grant_b;
  assign w_accept  = w_grant_a || w_grant_b;

  assign w_addr  = w_grant_b ? b_addr  : a_addr;
  assign w_wdata = w_grant_b ? b_wdata : a_wdata;
  assign w_we    = w_grant_b ? b_we    : a_we;
  assign w_size  = w_grant_b ? b_size  : a_size;
  assign w_word  = w_size[1];

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign w_misalign = ((w_size == 2'b01) && w_addr[0]) || (w_word && (w_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_rmw = w_we && !w_word && !w_misalign;

  always_comb begin
    w_state_nxt = r_state;
    a_ready     = w_grant_a;
    b_ready     = w_grant_b;
    ram_r_addr  = '0;
    ram_w_addr  = '0;
    ram_wd      = '0;
    ram_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          ram_r_addr  = w_addr;
          w_state_nxt = w_rmw ? RMW_WR : RESP;
          if (w_we && w_word && !w_misalign) begin
            ram_we     = 1'b1;
            ram_w_addr = w_addr;
            ram_wd     = w_wdata;
          end
        end
      end
      RMW_WR: begin
        ram_we      = 1'b1;
        ram_w_addr  = r_addr;
        ram_wd      = r_half ? {r_rdata[DATA_WIDTH-1:16], r_wdata[15:0]}
                             : {r_rdata[DATA_WIDTH-1:8],  r_wdata[7:0]};
        w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // a write pending in the reset cycle must never reach the RAM
    if (rst) ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_prio_b <= RESET_PRIO_B;
      r_sel_b  <= 1'b0;
      r_err    <= 1'b0;
      r_half   <= 1'b0;
      r_rdata  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_prio_b <= !w_grant_b;
        r_sel_b  <= w_grant_b;
        r_err    <= w_misalign;
        r_half   <= (w_size == 2'b01);
        r_addr   <= w_addr;
        r_wdata  <= w_wdata[15:0];
        if (w_misalign || (w_we && w_word)) r_rdata <= '0;
        else                                r_rdata <= ram_rd;
      end else if (r_state == RMW_WR) begin
        r_rdata <= '0;
      end
    end
  end

  assign w_resp       = (r_state == RESP) && !rst;
  assign a_resp_valid = w_resp && !r_sel_b;
  assign b_resp_valid = w_resp && r_sel_b;
  assign a_rdata      = a_resp_valid ? r_rdata : '0;
  assign b_rdata      = b_resp_valid ? r_rdata : '0;
  assign a_err        = a_resp_valid && r_err;
  assign b_err        = b_resp_valid && r_err;
  assign busy         = (r_state != IDLE) && !rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic checked against a transaction-level model of arbitration, latency and memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int DW = 32;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic a_valid, a_ready, a_we, a_resp_valid, a_err;
  logic b_valid, b_ready, b_we, b_resp_valid, b_err;
  logic [1:0] a_size, b_size;
  logic [DW-1:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic [DW-1:0] ram_r_addr, ram_rd, ram_w_addr, ram_wd;
  logic ram_we, busy;

  dmem_arbiter #(.DATA_WIDTH(DW), .RESET_PRIO_B(1'b0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we),
    .a_size(a_size), .a_resp_valid(a_resp_valid), .a_rdata(a_rdata), .a_err(a_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we),
    .b_size(b_size), .b_resp_valid(b_resp_valid), .b_rdata(b_rdata), .b_err(b_err),
    .ram_r_addr(ram_r_addr), .ram_rd(ram_rd), .ram_w_addr(ram_w_addr), .ram_wd(ram_wd),
    .ram_we(ram_we), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model (4 KiB window, little-endian, 4-byte write) and reference memory
  logic [7:0] ram     [0:4095];
  logic [7:0] ref_mem [0:4095];

  always_comb begin
    ram_rd = {ram[12'(ram_r_addr + 32'd3)], ram[12'(ram_r_addr + 32'd2)],
              ram[12'(ram_r_addr + 32'd1)], ram[ram_r_addr[11:0]]};
  end

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_w_addr[11:0]]          <= ram_wd[7:0];
      ram[12'(ram_w_addr + 32'd1)]   <= ram_wd[15:8];
      ram[12'(ram_w_addr + 32'd2)]   <= ram_wd[23:16];
      ram[12'(ram_w_addr + 32'd3)]   <= ram_wd[31:24];
    end
  end

  typedef struct {
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          port_b;
    req_t        r;
    bit          chk_rd;
    logic [31:0] exp_rdata;
    bit          exp_err;
    logic [31:0] exp_mem;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          m_prio_b;
  int          first_grant;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {ram[12'(a + 32'd3)], ram[12'(a + 32'd2)], ram[12'(a + 32'd1)], ram[a[11:0]]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[12'(a + 32'd3)], ref_mem[12'(a + 32'd2)], ref_mem[12'(a + 32'd1)], ref_mem[a[11:0]]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] size);
    int nbytes;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    for (int k = 0; k < nbytes; k++) ref_mem[12'(a + 32'(k))] = d[8*k +: 8];
  endtask

  function automatic bit misaligned(input req_t r);
    return ALIGN_EN && (((r.size == 2'b01) && r.addr[0]) || (r.size[1] && (r.addr[1:0] != 2'b00)));
  endfunction

  // Presents up to one request per port and runs until both are served and answered.
  task automatic run_pair(input req_t ra, input bit va, input req_t rb, input bit vb);
    bit pa, pb, ga, gb, side_b, e_err, e_chk, mis, exp_we;
    int bcnt, cyc;
    logic [31:0] e_rdata, e_addr, exp_wa;
    req_t g;
    pa = va; pb = vb; bcnt = 0; cyc = 0; first_grant = -1;
    side_b = 1'b0; e_err = 1'b0; e_chk = 1'b0; e_rdata = '0; e_addr = '0;
    a_addr = ra.addr; a_wdata = ra.wdata; a_we = ra.we; a_size = ra.size;
    b_addr = rb.addr; b_wdata = rb.wdata; b_we = rb.we; b_size = rb.size;
    while ((pa || pb || bcnt > 0) && cyc < 40) begin
      a_valid = pa;
      b_valid = pb;
      #1;
      ga = 1'b0; gb = 1'b0;
      if (bcnt == 0) begin
        gb = pb && (!pa || m_prio_b);
        ga = pa && !gb;
      end
      chk1("a_ready", a_ready, ga);
      chk1("b_ready", b_ready, gb);
      chk1("a_resp_valid", a_resp_valid, (bcnt == 1) && !side_b);
      chk1("b_resp_valid", b_resp_valid, (bcnt == 1) && side_b);
      chk1("busy", busy, bcnt > 0);
      if (bcnt == 1) begin
        last_rdata = side_b ? b_rdata : a_rdata;
        last_err   = side_b ? b_err   : a_err;
        if (e_chk) chk32("resp_rdata", last_rdata, e_rdata);
        chk1("resp_err", last_err, e_err);
        chk32("mem_word", ram_word(e_addr), ref_word(e_addr));
      end
      mis = 1'b0;
      g   = gb ? rb : ra;
      if (ga || gb) begin
        mis    = misaligned(g);
        exp_we = g.we && g.size[1] && !mis;
        exp_wa = g.addr;
      end else begin
        exp_we = (bcnt == 2);
        exp_wa = e_addr;
      end
      chk1("ram_we", ram_we, exp_we);
      if (exp_we) chk32("ram_w_addr", ram_w_addr, exp_wa);
      if (ga || gb) begin
        if (first_grant < 0) first_grant = gb ? 1 : 0;
        m_prio_b = !gb;
        side_b   = gb;
        e_addr   = g.addr;
        e_err    = mis;
        e_chk    = !g.we || g.size[1] || mis;
        e_rdata  = (g.we || mis) ? 32'h0 : ref_word(g.addr);
        if (g.we && !mis) ref_store(g.addr, g.wdata, g.size);
        bcnt = (g.we && !g.size[1] && !mis) ? 2 : 1;
        if (gb) pb = 1'b0; else pa = 1'b0;
      end else if (bcnt > 0) begin
        bcnt--;
      end
      cyc++;
      @(negedge clk);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (cyc >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_pair_timeout: got %0d cycles expected completion below 40", cyc);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.addr  = 32'h0001_0000 + 32'($urandom_range(0, 4080));
    r.we    = 1'($urandom_range(0, 1));
    r.size  = 2'($urandom_range(0, 3));
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    m_prio_b = 1'b0;
  endtask

  vec_t tbl [7];
  req_t idle_r, ra, rb;

  initial begin
    tbl[0] = '{1'b0, '{1'b0, 2'b10, 32'h0001_0000, 32'h0},         1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{1'b1, '{1'b1, 2'b10, 32'h0001_0008, 32'h12345678},  1'b1, 32'h0,        1'b0, 32'h12345678};
    tbl[2] = '{1'b0, '{1'b0, 2'b10, 32'h0001_0008, 32'h0},         1'b1, 32'h12345678, 1'b0, 32'h12345678};
    tbl[3] = '{1'b0, '{1'b1, 2'b00, 32'h0001_0008, 32'hFFFF_FFAB}, 1'b0, 32'h0,        1'b0, 32'h123456AB};
    tbl[4] = '{1'b0, '{1'b1, 2'b01, 32'h0001_0008, 32'hFFFF_CDEF}, 1'b0, 32'h0,        1'b0, 32'h1234CDEF};
    tbl[5] = '{1'b1, '{1'b0, 2'b11, 32'h0001_0008, 32'h0},         1'b1, 32'h1234CDEF, 1'b0, 32'h1234CDEF};
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    tbl[6] = '{1'b0, '{1'b1, 2'b10, 32'h0001_0002, 32'hCAFEF00D},  1'b1, 32'h0,        1'b1, 32'h3344DEAD};
`else
    tbl[6] = '{1'b0, '{1'b1, 2'b10, 32'h0001_0002, 32'hCAFEF00D},  1'b1, 32'h0,        1'b0, 32'hCAFEF00D};
`endif
    idle_r = '{1'b0, 2'b00, 32'h0, 32'h0};

    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b0;
    a_addr = '0; a_wdata = '0; a_we = 1'b0; a_size = 2'b10;
    b_addr = '0; b_wdata = '0; b_we = 1'b0; b_size = 2'b10;
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    ram[0] <= 8'hEF; ram[1] <= 8'hBE; ram[2] <= 8'hAD; ram[3] <= 8'hDE;
    ram[4] <= 8'h44; ram[5] <= 8'h33; ram[6] <= 8'h22; ram[7] <= 8'h11;
    ref_mem[0] = 8'hEF; ref_mem[1] = 8'hBE; ref_mem[2] = 8'hAD; ref_mem[3] = 8'hDE;
    ref_mem[4] = 8'h44; ref_mem[5] = 8'h33; ref_mem[6] = 8'h22; ref_mem[7] = 8'h11;

    repeat (3) @(negedge clk);
    #1;
    chk1("rst_a_ready", a_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_a_resp_valid", a_resp_valid, 1'b0);
    chk1("rst_b_resp_valid", b_resp_valid, 1'b0);
    chk32("rst_a_rdata", a_rdata, 32'h0);
    chk1("rst_ram_we", ram_we, 1'b0);
    a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_prio_b = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_pair(tbl[i].r, !tbl[i].port_b, tbl[i].r, tbl[i].port_b);
      if (tbl[i].chk_rd) chk32("tbl_rdata", last_rdata, tbl[i].exp_rdata);
      chk1("tbl_err", last_err, tbl[i].exp_err);
      chk32("tbl_mem", ram_word(tbl[i].r.addr), tbl[i].exp_mem);
    end

    // both requesters held valid from reset: A first, then alternation
    do_reset(2);
    ra = '{1'b0, 2'b10, 32'h0001_0000, 32'h0};
    rb = '{1'b0, 2'b10, 32'h0001_0004, 32'h0};
    for (int k = 0; k < 3; k++) begin
      run_pair(ra, 1'b1, rb, 1'b1);
      chk32("both_first_grant", 32'(first_grant), 32'd0);
    end

    // reset during the RMW write cycle of a byte store
    a_addr = 32'h0001_0008; a_wdata = 32'h0000_0055; a_we = 1'b1; a_size = 2'b00;
    a_valid = 1'b1;
    #1;
    chk1("rmwrst_accept", a_ready, 1'b1);
    chk1("rmwrst_no_we_at_accept", ram_we, 1'b0);
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk1("rmwrst_ram_we", ram_we, 1'b0);
    chk1("rmwrst_resp", a_resp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_prio_b = 1'b0;
    #1;
    chk1("rmwrst_busy", busy, 1'b0);
    chk1("rmwrst_resp_after", a_resp_valid, 1'b0);
    chk1("rmwrst_we_after", ram_we, 1'b0);
    chk32("rmwrst_mem", ram_word(32'h0001_0008), 32'h1234CDEF);
    @(negedge clk);
    #1;
    chk1("rmwrst_resp_late", a_resp_valid, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      int s;
      s  = int'($urandom_range(0, 2));
      ra = rand_req();
      rb = rand_req();
      run_pair(ra, s != 1, rb, s != 0);
    end
    run_pair(idle_r, 1'b0, idle_r, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected end of test before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
